// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle add/subtract unit.
// Operands are latched on an accepted start and then consumed DIGIT bits per
// clock, LSB digit first, through a DIGIT-bit adder slice. The full-width
// result, its carry-out and the signed overflow / zero flags are published
// together when the last digit completes, so they never show a partial sum.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result,
   output logic             overflow,
   output logic             zero
);

   // Number of RUN cycles per operation and the step counter sizing.
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   // FSM encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Parameter legality: the digit must tile the operand exactly.
   generate
      if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
         $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] a_sr;        // remaining digits of A
   logic [WIDTH-1:0] b_sr;        // remaining digits of B'
   logic [WIDTH-1:0] sum_sr;      // sum digits, filled from the top
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             a_msb_q;     // sign of A, kept for the overflow test
   logic             b_msb_q;     // sign of B', kept for the overflow test

   logic             accept;
   logic             last_step;
   logic [WIDTH-1:0] b_eff;
   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;

   // A request is taken in IDLE and also in DONE, which gives back-to-back
   // operation without an idle gap.
   assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_STEP);

   // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
   assign b_eff = op ? ~b : b;

   // Digit slice and shift datapath.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      logic [WIDTH+DIGIT-1:0] sum_wide;
      logic [WIDTH+DIGIT-1:0] a_wide;
      logic [WIDTH+DIGIT-1:0] b_wide;
      digit_sum = '0;
      sum_next  = '0;
      a_next    = '0;
      b_next    = '0;

      digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

      // Widened concatenations keep the shifts legal even when DIGIT == WIDTH.
      sum_wide = {digit_sum[DIGIT-1:0], sum_sr};
      a_wide   = {{DIGIT{1'b0}}, a_sr};
      b_wide   = {{DIGIT{1'b0}}, b_sr};
      sum_next = sum_wide[WIDTH+DIGIT-1:DIGIT];
      a_next   = a_wide[WIDTH+DIGIT-1:DIGIT];
      b_next   = b_wide[WIDTH+DIGIT-1:DIGIT];
   end

   // Next-state selection for IDLE -> RUN -> DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_RUN;
         ST_RUN:  if (last_step) state_d = ST_DONE;
         ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset mid-operation simply drops the job.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latch, digit-serial accumulation and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (accept) begin
         a_sr    <= a;
         b_sr    <= b_eff;
         sum_sr  <= '0;
         carry_q <= op;
         cnt_q   <= '0;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b_eff[WIDTH-1];
      end else if (state_q == ST_RUN) begin
         a_sr    <= a_next;
         b_sr    <= b_next;
         sum_sr  <= sum_next;
         carry_q <= digit_sum[DIGIT];
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   // Published result and flags: written only on the final RUN edge and
   // held through IDLE and the next RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (last_step) begin
         result   <= {digit_sum[DIGIT], sum_next};
         overflow <= (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
         zero     <= (sum_next == '0);
      end
   end

   // Handshake outputs decode directly from the state register.
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed bench for addsub_serial using a 4-bit/1-bit
// instance and an 8-bit/2-bit instance sharing clock and reset.
module tb_addsub_serial;

   logic clk;
   logic rst_n;

   logic       start4, op4;
   logic [3:0] a4, b4;
   logic       busy4, done4, ovf4, zero4;
   logic [4:0] res4;

   logic       start8, op8;
   logic [7:0] a8, b8;
   logic       busy8, done8, ovf8, zero8;
   logic [8:0] res8;

   int passed = 0;
   int total  = 0;

   addsub_serial #(.WIDTH(4), .DIGIT(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(res4), .overflow(ovf4), .zero(zero4)
   );

   addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .overflow(ovf8), .zero(zero8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request for one edge on the 4-bit unit; returns at the
   // negedge after the accepting edge with start already dropped.
   task automatic issue4(input logic o, input logic [3:0] x, input logic [3:0] y);
      @(negedge clk);
      start4 = 1'b1; op4 = o; a4 = x; b4 = y;
      @(negedge clk);
      start4 = 1'b0;
   endtask

   task automatic issue8(input logic o, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Bounded wait for done; n = negedges elapsed since the accepting edge.
   task automatic wait_done4(output int n);
      n = 0;
      while (!done4 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start4 = 0; op4 = 0; a4 = 0; b4 = 0;
      start8 = 0; op8 = 0; a8 = 0; b8 = 0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy4, done4, res4, ovf4, zero4} !== 9'b0) begin
         $display("FAIL reset4: got busy=%b done=%b res=%b ovf=%b zero=%b, want all 0",
                  busy4, done4, res4, ovf4, zero4);
      end else passed++;
      total++;
      if ({busy8, done8, res8, ovf8, zero8} !== 13'b0) begin
         $display("FAIL reset8: got busy=%b done=%b res=%b ovf=%b zero=%b, want all 0",
                  busy8, done8, res8, ovf8, zero8);
      end else passed++;
      rst_n = 1'b1;
   endtask

   // Scenario 1: 13 - 1 on the 4-bit unit, with latency and done width.
   task automatic test_sub_basic;
      int n;
      issue4(1'b1, 4'b1101, 4'b0001);
      total++;
      if (busy4 !== 1'b1) $display("FAIL sub_basic_busy: got %b want 1", busy4);
      else passed++;
      wait_done4(n);
      total++;
      if (n !== 4) $display("FAIL sub_basic_latency: got %0d want 4", n);
      else passed++;
      total++;
      if ({res4, ovf4, zero4} !== {5'b11100, 1'b0, 1'b0})
         $display("FAIL sub_basic_result: got res=%b ovf=%b zero=%b want res=11100 ovf=0 zero=0",
                  res4, ovf4, zero4);
      else passed++;
      @(negedge clk);
      total++;
      if ({done4, busy4} !== 2'b00) $display("FAIL sub_basic_done_pulse: got done=%b busy=%b want 0 0", done4, busy4);
      else passed++;
      total++;
      if (res4 !== 5'b11100) $display("FAIL sub_basic_hold: got %b want 11100", res4);
      else passed++;
   endtask

   // Scenario 2: signed overflow on subtract and a borrow case.
   task automatic test_sub_overflow;
      int n;
      issue4(1'b1, 4'b1000, 4'b0010);
      wait_done4(n);
      total++;
      if ({res4, ovf4, zero4} !== {5'b10110, 1'b1, 1'b0})
         $display("FAIL sub_ovf: got res=%b ovf=%b zero=%b want res=10110 ovf=1 zero=0", res4, ovf4, zero4);
      else passed++;
      issue4(1'b1, 4'b0011, 4'b1111);
      total++;
      if (res4 !== 5'b10110) $display("FAIL sub_borrow_no_partial: got %b want 10110", res4);
      else passed++;
      wait_done4(n);
      total++;
      if ({res4, ovf4, zero4} !== {5'b00100, 1'b0, 1'b0})
         $display("FAIL sub_borrow: got res=%b ovf=%b zero=%b want res=00100 ovf=0 zero=0", res4, ovf4, zero4);
      else passed++;
   endtask

   // Scenario 3: 8-bit, two bits per clock, add with carry-out and overflow.
   task automatic test_add_wide;
      int n;
      issue8(1'b0, 8'd200, 8'd100);
      wait_done8(n);
      total++;
      if (n !== 4) $display("FAIL add8_latency: got %0d want 4", n);
      else passed++;
      total++;
      if ({res8, ovf8, zero8} !== {9'h12C, 1'b0, 1'b0})
         $display("FAIL add8_carry: got res=%h ovf=%b zero=%b want res=12c ovf=0 zero=0", res8, ovf8, zero8);
      else passed++;
      issue8(1'b0, 8'h7F, 8'h01);
      wait_done8(n);
      total++;
      if ({res8, ovf8, zero8} !== {9'h080, 1'b1, 1'b0})
         $display("FAIL add8_ovf: got res=%h ovf=%b zero=%b want res=080 ovf=1 zero=0", res8, ovf8, zero8);
      else passed++;
   endtask

   // Scenario 4: zero result, then a request taken in the done cycle.
   task automatic test_back_to_back;
      int n;
      issue4(1'b1, 4'd5, 4'd5);
      wait_done4(n);
      total++;
      if ({res4, ovf4, zero4} !== {5'b10000, 1'b0, 1'b1})
         $display("FAIL b2b_zero: got res=%b ovf=%b zero=%b want res=10000 ovf=0 zero=1", res4, ovf4, zero4);
      else passed++;
      start4 = 1'b1; op4 = 1'b0; a4 = 4'd1; b4 = 4'd2;
      @(negedge clk);
      start4 = 1'b0;
      total++;
      if ({busy4, done4} !== 2'b10) $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy4, done4);
      else passed++;
      wait_done4(n);
      total++;
      if (n !== 4) $display("FAIL b2b_latency: got %0d want 4", n);
      else passed++;
      total++;
      if ({res4, ovf4, zero4} !== {5'b00011, 1'b0, 1'b0})
         $display("FAIL b2b_result: got res=%b ovf=%b zero=%b want res=00011 ovf=0 zero=0", res4, ovf4, zero4);
      else passed++;
   endtask

   // Scenario 5: start and operand changes during RUN are ignored.
   task automatic test_start_in_run;
      int pulses;
      issue4(1'b0, 4'd3, 4'd1);
      @(negedge clk);
      start4 = 1'b1; op4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
      @(negedge clk);
      start4 = 1'b0;
      pulses = 0;
      if (done4) pulses++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4) pulses++;
      end
      total++;
      if (pulses !== 1) $display("FAIL run_ignore_pulses: got %0d want 1", pulses);
      else passed++;
      total++;
      if ({res4, ovf4, zero4} !== {5'b00100, 1'b0, 1'b0})
         $display("FAIL run_ignore_result: got res=%b ovf=%b zero=%b want res=00100 ovf=0 zero=0", res4, ovf4, zero4);
      else passed++;
   endtask

   // Scenario 6: asynchronous reset in the middle of RUN.
   task automatic test_reset_mid_run;
      int pulses;
      int n;
      issue4(1'b0, 4'd6, 4'd7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy4, done4, res4, ovf4, zero4} !== 9'b0)
         $display("FAIL midrun_reset: got busy=%b done=%b res=%b ovf=%b zero=%b want all 0",
                  busy4, done4, res4, ovf4, zero4);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done4) pulses++;
      end
      total++;
      if (pulses !== 0) $display("FAIL midrun_no_done: got %0d pulses want 0", pulses);
      else passed++;
      issue4(1'b0, 4'd6, 4'd7);
      wait_done4(n);
      total++;
      if (n !== 4) $display("FAIL midrun_recover_latency: got %0d want 4", n);
      else passed++;
      total++;
      if ({res4, ovf4, zero4} !== {5'b01101, 1'b1, 1'b0})
         $display("FAIL midrun_recover: got res=%b ovf=%b zero=%b want res=01101 ovf=1 zero=0", res4, ovf4, zero4);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_sub_basic;
      test_sub_overflow;
      test_add_wide;
      test_back_to_back;
      test_start_in_run;
      test_reset_mid_run;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
